clk_divider_prog: RTL
=====================

# clk_divider_prog

Parametrised, runtime-programmable clock divider. It replaces the fixed divide-by-8 divider as the frequency source for slow peripherals. The divisor is loaded through a single-cycle load strobe and takes effect only at a period boundary, so the output never glitches. The block supports even and odd divisors, a ~50% duty mode and a one-cycle pulse mode, and gates the output cleanly on enable.

## Interface
- WIDTH, 8, width of divisor and internal counter; max divisor 2^WIDTH-1
- RESET_DIV, 8, divisor in force after reset; must be in 2..2^WIDTH-1
- clk  input  1  single system clock; all logic on rising edge
- reset  input  1  synchronous, active-low reset (reset==0 sampled at posedge resets the block)
- enable  input  1  run request; sampled every cycle
- mode  input  1  0 = duty mode (high ceil(N/2) cycles), 1 = pulse mode (high 1 cycle)
- div_load  input  1  one-cycle strobe; captures div_value
- div_value  input  WIDTH  requested divisor N
- out_clk  output  1  divided clock, registered
- tick  output  1  one-cycle pulse in the first high cycle of each out_clk period, registered
- pending  output  1  a loaded divisor is waiting for the next boundary
- cfg_err  output  1  one-cycle pulse: rejected load (div_value < 2)

## Operation
- State machine with two states:
  - IDLE: cnt=0, out_clk=0.
  - RUN: cnt counts 0..N-1.
- Active divisor N and active mode M are registers. They update only in IDLE or at a boundary.
- High length: H = (N+1)>>1 when M=0; H = 1 when M=1. Compute H in WIDTH+1 bits so N = 2^WIDTH-1 does not overflow.
- Phase: out_clk is high in cycles with cnt in [0, H-1] and low for cnt in [H, N-1]. Odd N in duty mode gives one extra high cycle (N=5: 3 high, 2 low).
- IDLE -> RUN: on an edge where enable=1, set cnt<=0, out_clk<=1, tick<=1, and latch mode into M.
- Boundary: any edge in RUN with cnt==N-1.
  - If enable=1: cnt<=0, out_clk<=1, tick<=1. Apply the pending divisor if any, clear pending, and re-latch M from mode.
  - If enable=0: go to IDLE with out_clk<=0. Any pending divisor is applied on entry to IDLE.
- enable deassertion mid-period has no effect until the boundary, so the last period is always complete.
- Divisor load (div_load=1, div_value>=2):
  - In IDLE: N <= div_value at that edge; pending stays 0.
  - In RUN, not on a boundary edge: store div_value in the pending register and set pending<=1. A later load overwrites it (last wins).
  - In RUN, on a boundary edge: div_value is applied at that boundary directly, overriding any older pending value; pending<=0.
- Rejected load (div_value < 2): cfg_err<=1 for one cycle. N, the pending register and the pending flag are unchanged.
- mode changes mid-period are ignored until the next boundary or start.

## Timing
- Reset values: out_clk=0, tick=0, pending=0, cfg_err=0, state IDLE, cnt=0, N=RESET_DIV, M=0, pending register cleared.
- Reset mid-run: all outputs take their reset values at that edge. The output period is truncated; this is the only permitted truncation.
- Start latency: enable sampled high at edge k in IDLE gives out_clk=1 and tick=1 in the cycle after edge k.
- Period is exactly N clk cycles in steady state. tick has a period of N cycles and a width of 1 cycle.
- A divisor loaded in RUN takes effect at the first boundary at or after the load edge. The current period always finishes with the old N.
- pending rises one edge after a non-boundary load and falls at the boundary edge that applies it.
- No combinational paths from inputs to outputs.

## Test plan
- Reset defaults, enable=1, mode=0 → out_clk pattern is 4 high / 4 low repeating; tick every 8 cycles; first out_clk high 1 cycle after enable is sampled.
- Load N=5 in IDLE, mode=0, enable → out_clk 3 high / 2 low, period 5. Load N=255 (WIDTH=8) → 128 high / 127 low.
- Running at N=8, load N=3 at cnt=2 → pending=1; current period completes 8 cycles; then 2 high / 1 low; pending clears at the boundary. Two loads in one period (6, then 4) → only 4 is applied.
- Load div_value=1 and then 0 while running → cfg_err pulses for 1 cycle each; period stays 8; pending stays 0.
- mode=1 with N=4 → out_clk and tick both high 1 of every 4 cycles. Switching mode mid-period → the change takes effect at the next boundary only.
- Drop enable at cnt=1 (N=8) → the period completes, out_clk goes low and stays low, state is IDLE. Assert reset=0 mid-high-phase in a separate run → out_clk=0 at the next edge, and N returns to 8.

Source files
------------

// File: rtl/clk_divider_prog_if.sv
// clk_divider_prog_if: control/status bundle for the programmable clock divider.
//   master (controller side): drives enable, mode, div_load, div_value;
//                             observes out_clk, tick, pending, cfg_err.
//   slave  (divider side):    the reverse.
// WIDTH must match the WIDTH of the clk_divider_prog instance it is bound to.
interface clk_divider_prog_if #(
  parameter int WIDTH = 8
);
  logic             enable;
  logic             mode;
  logic             div_load;
  logic [WIDTH-1:0] div_value;
  logic             out_clk;
  logic             tick;
  logic             pending;
  logic             cfg_err;

  modport master (
    output enable, mode, div_load, div_value,
    input  out_clk, tick, pending, cfg_err
  );

  modport slave (
    input  enable, mode, div_load, div_value,
    output out_clk, tick, pending, cfg_err
  );
endinterface

// File: rtl/clk_divider_prog.sv
// clk_divider_prog: runtime-programmable, glitch-free clock divider.
//   clk    : system clock, everything on the rising edge
//   reset  : synchronous, active-low
//   bus    : clk_divider_prog_if.slave
//     enable    run request; a stop only takes effect at a period boundary
//     mode      0 = ~50% duty (high ceil(N/2)), 1 = one-cycle pulse
//     div_load  one-cycle strobe capturing div_value (must be >= 2)
//     div_value requested divisor N
//     out_clk   divided clock (registered)
//     tick      one-cycle pulse in the first high cycle of each period
//     pending   a loaded divisor waits for the next boundary
//     cfg_err   one-cycle pulse on a rejected load (div_value < 2)
// Divisor and mode changes only land at a period boundary or while idle, so
// the output period is never cut short except by reset.
module clk_divider_prog #(
  parameter int WIDTH     = 8,
  parameter int RESET_DIV = 8
) (
  input  logic             clk,
  input  logic             reset,
  clk_divider_prog_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] cnt, cnt_d;
  logic [WIDTH-1:0] div_n, div_d;       // active divisor
  logic [WIDTH-1:0] pend_div, pdiv_d;   // divisor waiting for a boundary
  logic             pend_q, pend_d;
  logic             mode_m, mode_d;     // active mode
  logic             out_q, out_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;

  logic             load_ok, load_bad, boundary;
  logic [WIDTH:0]   hi_len, cnt_inc;

  assign load_bad = bus.div_load && (bus.div_value < WIDTH'(2));
  assign load_ok  = bus.div_load && !load_bad;
  assign boundary = (state == RUN) && (cnt == div_n - WIDTH'(1));

  // One extra bit so (N+1)>>1 survives N = 2^WIDTH-1.
  assign hi_len  = mode_m ? (WIDTH+1)'(1)
                          : (({1'b0, div_n} + (WIDTH+1)'(1)) >> 1);
  assign cnt_inc = {1'b0, cnt} + (WIDTH+1)'(1);

  // state register + datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      div_n    <= WIDTH'(RESET_DIV);
      pend_div <= '0;
      pend_q   <= 1'b0;
      mode_m   <= 1'b0;
      out_q    <= 1'b0;
      tick_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_d;
      div_n    <= div_d;
      pend_div <= pdiv_d;
      pend_q   <= pend_d;
      mode_m   <= mode_d;
      out_q    <= out_d;
      tick_q   <= tick_d;
      err_q    <= err_d;
    end
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.enable) state_nx = RUN;
      RUN:     if (boundary && !bus.enable) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // next values of the registered outputs and datapath
  always_comb begin
    cnt_d  = cnt;
    div_d  = div_n;
    pdiv_d = pend_div;
    pend_d = pend_q;
    mode_d = mode_m;
    out_d  = 1'b0;
    tick_d = 1'b0;
    err_d  = load_bad;
    case (state)
      IDLE: begin
        cnt_d  = '0;
        pend_d = 1'b0;
        if (load_ok) div_d = bus.div_value;
        if (bus.enable) begin
          out_d  = 1'b1;
          tick_d = 1'b1;
          mode_d = bus.mode;
        end
      end
      RUN: begin
        if (boundary) begin
          cnt_d  = '0;
          pend_d = 1'b0;
          // A load on the boundary edge itself wins over an older pending one.
          if (load_ok)     div_d = bus.div_value;
          else if (pend_q) div_d = pend_div;
          if (bus.enable) begin
            out_d  = 1'b1;
            tick_d = 1'b1;
            mode_d = bus.mode;
          end
        end else begin
          cnt_d = cnt + WIDTH'(1);
          out_d = (cnt_inc < hi_len);
          if (load_ok) begin
            pdiv_d = bus.div_value;
            pend_d = 1'b1;
          end
        end
      end
      default: cnt_d = '0;
    endcase
  end

  assign bus.out_clk = out_q;
  assign bus.tick    = tick_q;
  assign bus.pending = pend_q;
  assign bus.cfg_err = err_q;

endmodule
